// File: rtl/spi_baud_generator_if.sv
// spi_baud_generator_if: configuration, slave-select and timing-output bundle for the
// SPI baud generator. The master modport belongs to the block that drives the
// configuration inputs. The slave modport belongs to the generator itself.
interface spi_baud_generator_if #(
   parameter int unsigned DIV_W = 12
);
   logic [1:0]       spi_mode;
   logic             spiswai;
   logic [2:0]       sppr;
   logic [2:0]       spr;
   logic             cpol;
   logic             cpha;
   logic             ss;
   logic             sclk;
   logic [DIV_W-1:0] baudratedivisor;
   logic             sample_pulse;
   logic             drive_pulse;
   logic [4:0]       edge_cnt;

   modport master (
      output spi_mode, spiswai, sppr, spr, cpol, cpha, ss,
      input  sclk, baudratedivisor, sample_pulse, drive_pulse, edge_cnt
   );

   modport slave (
      input  spi_mode, spiswai, sppr, spr, cpol, cpha, ss,
      output sclk, baudratedivisor, sample_pulse, drive_pulse, edge_cnt
   );
endinterface

// File: rtl/spi_baud_generator.sv
// spi_baud_generator: SPI serial-clock and bit-timing generator.
// The divisor is (sppr+1) << (spr+1) PCLK cycles per sclk half-period.
// sclk runs while ss is low and the mode permits it. The sample and drive strobes
// fire in the cycle before each sclk edge.
// Optional feature macro: SPI_BAUD_EDGE_CNT_EN enables the saturating sclk edge
// counter. Without the macro, edge_cnt is tied to zero.
module spi_baud_generator #(
   parameter int unsigned DIV_W = 12
) (
   input logic                 PCLK,
   input logic                 PRESETn,
   spi_baud_generator_if.slave bus
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic [DIV_W-1:0] prescale;
   logic [3:0]       shamt;
   logic [DIV_W-1:0] cnt_q;
   logic             sclk_q;
   logic             active;
   logic             wrap;
   logic             strobe_due;
   logic             leading;

   assign prescale = DIV_W'(bus.sppr) + DIV_W'(1);
   assign shamt    = {1'b0, bus.spr} + 4'd1;
   assign div_d    = prescale << shamt;

   assign active = !bus.ss && (bus.spi_mode == 2'b00 || bus.spi_mode == 2'b01) && !bus.spiswai;
   // >= so that a divisor shrunk mid-transfer still forces a wrap instead of running cnt out
   assign wrap   = cnt_q >= (div_q - DIV_W'(1));

   // Divisor register, refreshed every cycle from the prescaler fields
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         div_q <= DIV_W'(2);
      end else begin
         div_q <= div_d;
      end
   end

   // Half-period counter and sclk toggle; sclk parks at cpol whenever inactive
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else if (!active) begin
         cnt_q  <= '0;
         sclk_q <= bus.cpol;
      end else if (wrap) begin
         cnt_q  <= '0;
         sclk_q <= !sclk_q;
      end else begin
         cnt_q  <= cnt_q + DIV_W'(1);
      end
   end

   // Strobes are gated by reset so they drop at once when reset is asserted
   assign strobe_due = PRESETn && active && (cnt_q == div_q - DIV_W'(2));
   // The upcoming edge is leading when sclk still sits at its idle level
   assign leading    = (sclk_q == bus.cpol);

   always_comb begin
      bus.sample_pulse = strobe_due && (leading ^ bus.cpha);
      bus.drive_pulse  = strobe_due && !(leading ^ bus.cpha);
   end

   assign bus.sclk            = sclk_q;
   assign bus.baudratedivisor = div_q;

`ifdef SPI_BAUD_EDGE_CNT_EN
   logic [4:0] edge_q;

   // Count sclk toggles in the current activation, saturating at 16 (one byte)
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         edge_q <= 5'd0;
      end else if (!active) begin
         edge_q <= 5'd0;
      end else if (wrap && edge_q != 5'd16) begin
         edge_q <= edge_q + 5'd1;
      end
   end

   assign bus.edge_cnt = edge_q;
`else
   assign bus.edge_cnt = 5'd0;
`endif

endmodule

// File: tb/tb_spi_baud_generator.sv
// tb_spi_baud_generator: scoreboard bench for spi_baud_generator.
// Each driven cycle pushes its expected outputs to a queue. A negedge monitor pops
// those expected outputs and compares them with the outputs of the DUT.
module tb_spi_baud_generator;

   logic pclk = 1'b0;
   logic presetn = 1'b0;

   spi_baud_generator_if #(.DIV_W(12)) bus_if ();

   spi_baud_generator #(.DIV_W(12)) dut (
      .PCLK    (pclk),
      .PRESETn (presetn),
      .bus     (bus_if.slave)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      bit full;
      int sclk;
      int sample;
      int drive;
      int div;
      int ec;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic       cfg_cpol = 1'b0;
   logic       cfg_cpha = 1'b0;
   logic [1:0] cfg_mode = 2'b00;

   task automatic check_eq(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs for the k-th active cycle with divisor d, counted from cnt=0
   function automatic exp_t exp_active(input int d, input int k);
      exp_t e;
      int   half;
      bit   lead;
      bit   strobe;
      half     = k / d;
      lead     = (half % 2) == 0;
      strobe   = (k % d) == (d - 2);
      e.full   = 1'b1;
      e.sclk   = int'(cfg_cpol) ^ (half % 2);
      e.sample = int'(strobe && (lead ^ cfg_cpha));
      e.drive  = int'(strobe && !(lead ^ cfg_cpha));
      e.div    = d;
`ifdef SPI_BAUD_EDGE_CNT_EN
      e.ec     = (half > 16) ? 16 : half;
`else
      e.ec     = 0;
`endif
      return e;
   endfunction

   task automatic next_cycle();
      @(posedge pclk);
      #1;
   endtask

   // Inactive cycles: why 0 = ss high, 1 = spiswai, 2 = stop mode
   task automatic idle(input int n, input int why, input int sppr, input int spr,
                       input logic cpol, input logic cpha, input logic [1:0] mode);
      exp_t e;
      int   d;
      d = (sppr + 1) << (spr + 1);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         cfg_cpol = cpol;
         cfg_cpha = cpha;
         cfg_mode = mode;
         bus_if.sppr     = 3'(sppr);
         bus_if.spr      = 3'(spr);
         bus_if.cpol     = cpol;
         bus_if.cpha     = cpha;
         bus_if.spi_mode = (why == 2) ? 2'b10 : mode;
         bus_if.spiswai  = (why == 1);
         bus_if.ss       = (why == 0);
         e.full   = (i != 0);
         e.sclk   = int'(cpol);
         e.sample = 0;
         e.drive  = 0;
         e.div    = d;
         e.ec     = 0;
         sb.push_back(e);
      end
   endtask

   // Active cycles k0 .. k0+n-1 with divisor d
   task automatic run(input int d, input int k0, input int n);
      for (int k = k0; k < k0 + n; k++) begin
         next_cycle();
         bus_if.ss       = 1'b0;
         bus_if.spiswai  = 1'b0;
         bus_if.spi_mode = cfg_mode;
         sb.push_back(exp_active(d, k));
      end
   endtask

   // Scoreboard monitor
   always @(negedge pclk) begin : mon
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_eq("sample_pulse", int'(bus_if.sample_pulse), e.sample);
         check_eq("drive_pulse", int'(bus_if.drive_pulse), e.drive);
         if (e.full) begin
            check_eq("sclk", int'(bus_if.sclk), e.sclk);
            check_eq("divisor", int'(bus_if.baudratedivisor), e.div);
            check_eq("edge_cnt", int'(bus_if.edge_cnt), e.ec);
         end
      end
   end

   initial begin
      exp_t e;
      bus_if.spi_mode = 2'b00;
      bus_if.spiswai  = 1'b0;
      bus_if.sppr     = 3'd0;
      bus_if.spr      = 3'd0;
      bus_if.cpol     = 1'b0;
      bus_if.cpha     = 1'b0;
      bus_if.ss       = 1'b1;

      // Reset state
      #12;
      check_eq("rst_sclk", int'(bus_if.sclk), 0);
      check_eq("rst_div", int'(bus_if.baudratedivisor), 2);
      check_eq("rst_sample", int'(bus_if.sample_pulse), 0);
      check_eq("rst_drive", int'(bus_if.drive_pulse), 0);
      check_eq("rst_edge_cnt", int'(bus_if.edge_cnt), 0);
      #10;
      presetn = 1'b1;

      // Divisor 2, mode 0
      idle(3, 0, 0, 0, 1'b0, 1'b0, 2'b00);
      run(2, 0, 20);

      // Divisor 12, a full byte of edges and then some
      idle(3, 0, 2, 1, 1'b0, 1'b0, 2'b00);
      run(12, 0, 215);

      // cpol=1, cpha=1, divisor 4
      idle(3, 0, 1, 0, 1'b1, 1'b1, 2'b00);
      run(4, 0, 24);

      // Wait mode, spiswai mid-transfer, then stop mode mid-transfer
      idle(2, 0, 0, 1, 1'b0, 1'b1, 2'b01);
      run(4, 0, 7);
      idle(3, 1, 0, 1, 1'b0, 1'b1, 2'b01);
      run(4, 0, 10);
      idle(3, 2, 0, 1, 1'b0, 1'b1, 2'b01);
      run(4, 0, 6);

      // Divisor 2048 shrinks to 2 while cnt is at 1000
      idle(2, 0, 7, 7, 1'b0, 1'b0, 2'b00);
      run(2048, 0, 999);
      next_cycle();
      bus_if.sppr = 3'd0;
      bus_if.spr  = 3'd0;
      sb.push_back(exp_active(2048, 999));
      next_cycle();
      e.full   = 1'b1;
      e.sclk   = 0;
      e.sample = 0;
      e.drive  = 0;
      e.div    = 2;
      e.ec     = 0;
      sb.push_back(e);
      run(2, 2, 12);

      // Asynchronous reset mid-transfer
      idle(2, 0, 1, 0, 1'b0, 1'b0, 2'b00);
      run(4, 0, 6);
      @(posedge pclk);
      #2;
      check_eq("pre_rst_sclk", int'(bus_if.sclk), 1);
      check_eq("pre_rst_drive", int'(bus_if.drive_pulse), 1);
      presetn = 1'b0;
      #1;
      check_eq("mid_rst_sclk", int'(bus_if.sclk), 0);
      check_eq("mid_rst_div", int'(bus_if.baudratedivisor), 2);
      check_eq("mid_rst_sample", int'(bus_if.sample_pulse), 0);
      check_eq("mid_rst_drive", int'(bus_if.drive_pulse), 0);
      check_eq("mid_rst_edge_cnt", int'(bus_if.edge_cnt), 0);
      #10;
      presetn = 1'b1;
      idle(3, 0, 1, 0, 1'b0, 1'b0, 2'b00);
      run(4, 0, 9);

      next_cycle();
      @(negedge pclk);
      #1;
      check_eq("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
